// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pipeline bundle and framebuffer helpers.
// Used by the scanout block and the plot-side adapter.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int FB_W  = 160;
  localparam int FB_H  = 120;
  localparam int FB_AW = 15;
  localparam int CW    = 10;

  typedef struct packed {
    logic vis;
    logic hs_n;
    logic vs_n;
    logic vblank;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{
    vis:    1'b0,
    hs_n:   1'b1,
    vs_n:   1'b1,
    vblank: 1'b0
  };

  // 4x4 screen pixels per cell; y*160 built from shifts
  function automatic logic [FB_AW-1:0] fb_index(
    input logic [CW-1:0] h,
    input logic [CW-1:0] v
  );
    logic [FB_AW-1:0] x;
    logic [FB_AW-1:0] y;
    x = FB_AW'(h >> 2);
    y = FB_AW'(v >> 2);
    return (y << 7) + (y << 5) + x;
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Raster position and raw sync flags from the timing
// generator to the scanout pipeline.
interface vga_scanout_if;
  import vga_pkg::*;

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          visible;
  logic          hsync_n;
  logic          vsync_n;

  modport master (
    output h_cnt, v_cnt, visible, hsync_n, vsync_n
  );

  modport slave (
    input h_cnt, v_cnt, visible, hsync_n, vsync_n
  );

endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters and undelayed
// visible / sync decode.
module vga_timing import vga_pkg::*; #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP
) (
  input  logic          clk,
  input  logic          reset,
  vga_scanout_if.master tim
);

  localparam int HT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_ON  = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0] HS_OFF =
    CW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_ON  = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0] VS_OFF =
    CW'(V_VISIBLE + V_FP + V_SYNC);

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign tim.h_cnt   = h_q;
  assign tim.v_cnt   = v_q;
  assign tim.visible = (h_q < H_VIS) && (v_q < V_VIS);
  assign tim.hsync_n = !((h_q >= HS_ON) && (h_q < HS_OFF));
  assign tim.vsync_n = !((v_q >= VS_ON) && (v_q < VS_OFF));

endmodule

// File: rtl/vga_scanout.sv
// 160x120x3 framebuffer scanout: address generation, 3-stage
// pipeline aligned with a 1-clk RAM, colour expansion.
module vga_scanout import vga_pkg::*; #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP
) (
  input  logic             clk,
  input  logic             reset,
  output logic [FB_AW-1:0] fb_addr,
  input  logic [2:0]       fb_data,
  output logic [3:0]       VGA_R,
  output logic [3:0]       VGA_G,
  output logic [3:0]       VGA_B,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK,
  output logic             VGA_SYNC,
  output logic             vblank
);

  localparam logic [CW-1:0] V_VIS = CW'(V_VISIBLE);

  vga_scanout_if tim ();

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_timing (
    .clk   (clk),
    .reset (reset),
    .tim   (tim)
  );

  sync_t s1_q, s1_d;
  sync_t s2_q, s2_d;
  sync_t s3_q, s3_d;

  logic [FB_AW-1:0] addr_q, addr_d;
  logic [11:0]      rgb_q, rgb_d;

  // fb_data arrives alongside stage 2, so gate with s2 visibility
  always_comb begin
    s1_d = '{
      vis:    tim.visible,
      hs_n:   tim.hsync_n,
      vs_n:   tim.vsync_n,
      vblank: (tim.v_cnt >= V_VIS)
    };
    s2_d   = s1_q;
    s3_d   = s2_q;
    addr_d = '0;
    if (tim.visible)
      addr_d = fb_index(tim.h_cnt, tim.v_cnt);
    rgb_d = '0;
    if (s2_q.vis)
      rgb_d = {{4{fb_data[2]}},
               {4{fb_data[1]}},
               {4{fb_data[0]}}};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q   <= SYNC_IDLE;
      s2_q   <= SYNC_IDLE;
      s3_q   <= SYNC_IDLE;
      addr_q <= '0;
      rgb_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      addr_q <= addr_d;
      rgb_q  <= rgb_d;
    end
  end

  assign fb_addr   = addr_q;
  assign VGA_R     = rgb_q[11:8];
  assign VGA_G     = rgb_q[7:4];
  assign VGA_B     = rgb_q[3:0];
  assign VGA_HS    = s3_q.hs_n;
  assign VGA_VS    = s3_q.vs_n;
  assign VGA_BLANK = s3_q.vis;
  assign VGA_SYNC  = 1'b0;
  assign vblank    = s3_q.vblank;

endmodule

// File: tb/tb_vga_scanout.sv
// Scanout bench on a reduced raster: per-clock model of the
// pins, sync edge timing, RAM model with 1-clk latency.
module tb_vga_scanout;
  import vga_pkg::*;

  localparam int HV  = 64;
  localparam int HFP = 4;
  localparam int HSY = 8;
  localparam int HBP = 4;
  localparam int HT  = HV + HFP + HSY + HBP;
  localparam int VV  = 48;
  localparam int VFP = 2;
  localparam int VSY = 2;
  localparam int VBP = 4;
  localparam int VT  = VV + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int FB_N  = FB_W * FB_H;

  logic             clk;
  logic             reset;
  logic [FB_AW-1:0] fb_addr;
  logic [2:0]       fb_data;
  logic [3:0]       VGA_R, VGA_G, VGA_B;
  logic             VGA_HS, VGA_VS;
  logic             VGA_BLANK, VGA_SYNC;
  logic             vblank;

  vga_scanout #(
    .H_VISIBLE (HV),  .H_FP (HFP),
    .H_SYNC    (HSY), .H_BP (HBP),
    .V_VISIBLE (VV),  .V_FP (VFP),
    .V_SYNC    (VSY), .V_BP (VBP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .VGA_R     (VGA_R),
    .VGA_G     (VGA_G),
    .VGA_B     (VGA_B),
    .VGA_HS    (VGA_HS),
    .VGA_VS    (VGA_VS),
    .VGA_BLANK (VGA_BLANK),
    .VGA_SYNC  (VGA_SYNC),
    .vblank    (vblank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit [2:0] fbmem [FB_N];

  int compared;
  int mismatched;
  int k;
  int prev_addr;
  int phase;
  int magenta;
  int maxaddr;
  int nf_hs, nf_vs;
  int hs_fall_k, vs_fall_k;
  logic prev_hs, prev_vs;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input int exp);
    compared++;
    assert (obs === 32'(exp)) else begin
      mismatched++;
      $error("FAIL %s: got %0h want %0h (k=%0d)",
             tag, obs, exp, k);
    end
  endtask

  task automatic load(input int mode);
    for (int i = 0; i < FB_N; i++) begin
      if (mode == 0) fbmem[i] = 3'b000;
      else if (mode == 1) fbmem[i] = 3'b111;
      else fbmem[i] = 3'($urandom_range(0, 7));
    end
    if (mode == 0) fbmem[2*FB_W + 5] = 3'b101;
  endtask

  // k = edges since reset release; raster position = index % frame
  task automatic check_pins();
    int n, h, v, ea;
    bit vis;
    logic [2:0] c;
    ea = 0;
    if (k >= 1) begin
      n = k - 1;
      h = n % HT;
      v = (n / HT) % VT;
      if (h < HV && v < VV) ea = (v / 4) * FB_W + h / 4;
    end
    chk("fb_addr", 32'(fb_addr), ea);
    chk("vga_sync", 32'(VGA_SYNC), 0);
    if (k >= 3) begin
      n = k - 3;
      h = n % HT;
      v = (n / HT) % VT;
      vis = (h < HV) && (v < VV);
      c = vis ? fbmem[(v / 4) * FB_W + h / 4] : 3'b000;
      chk("hs", 32'(VGA_HS),
          (h >= HV + HFP && h < HV + HFP + HSY) ? 0 : 1);
      chk("vs", 32'(VGA_VS),
          (v >= VV + VFP && v < VV + VFP + VSY) ? 0 : 1);
      chk("blank", 32'(VGA_BLANK), vis ? 1 : 0);
      chk("vblank", 32'(vblank), (v >= VV) ? 1 : 0);
      chk("r", 32'(VGA_R), c[2] ? 15 : 0);
      chk("g", 32'(VGA_G), c[1] ? 15 : 0);
      chk("b", 32'(VGA_B), c[0] ? 15 : 0);
    end else begin
      chk("hs_rst", 32'(VGA_HS), 1);
      chk("vs_rst", 32'(VGA_VS), 1);
      chk("blank_rst", 32'(VGA_BLANK), 0);
      chk("vblank_rst", 32'(vblank), 0);
      chk("rgb_rst", 32'({VGA_R, VGA_G, VGA_B}), 0);
    end
  endtask

  task automatic track_edges();
    if (k == 0) begin
      nf_hs   = HV + HFP + 3;
      nf_vs   = (VV + VFP) * HT + 3;
      prev_hs = 1'b1;
      prev_vs = 1'b1;
      return;
    end
    if (prev_hs === 1'b1 && VGA_HS === 1'b0) begin
      chk("hs_fall_at", k, nf_hs);
      nf_hs += HT;
      hs_fall_k = k;
    end
    if (prev_hs === 1'b0 && VGA_HS === 1'b1)
      chk("hs_low_len", k - hs_fall_k, HSY);
    if (prev_vs === 1'b1 && VGA_VS === 1'b0) begin
      chk("vs_fall_at", k, nf_vs);
      nf_vs += FRAME;
      vs_fall_k = k;
    end
    if (prev_vs === 1'b0 && VGA_VS === 1'b1)
      chk("vs_low_len", k - vs_fall_k, VSY * HT);
    prev_hs = VGA_HS;
    prev_vs = VGA_VS;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) k++;
    else k = 0;
    #1;
    check_pins();
    track_edges();
    if (phase == 0 && VGA_R == 4'hF &&
        VGA_G == 4'h0 && VGA_B == 4'hF)
      magenta++;
    if (k > 0 && int'(fb_addr) > maxaddr)
      maxaddr = int'(fb_addr);
    // RAM model: data follows the address by one clock
    if (prev_addr < FB_N) fb_data = fbmem[prev_addr];
    else fb_data = 3'b000;
    prev_addr = int'(fb_addr);
  endtask

  task automatic run_until(input int target);
    int guard;
    guard = 0;
    while (k < target && guard < 30000) begin
      step();
      guard++;
    end
    chk("run_bound", k, target);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    k          = 0;
    prev_addr  = 0;
    phase      = 0;
    magenta    = 0;
    maxaddr    = 0;
    hs_fall_k  = 0;
    vs_fall_k  = 0;
    prev_hs    = 1'b1;
    prev_vs    = 1'b1;
    nf_hs      = HV + HFP + 3;
    nf_vs      = (VV + VFP) * HT + 3;
    reset      = 1'b0;
    fb_data    = 3'b000;
    load(0);

    repeat (4) step();
    reset = 1'b1;

    run_until(FRAME + 50 * HT);
    chk("magenta_px", magenta, 32);

    phase = 1;
    load(1);
    run_until(2 * FRAME + 50 * HT);

    phase = 2;
    load(2);
    run_until(3 * FRAME + 20 * HT + 30);

    reset = 1'b0;
    step();
    reset = 1'b1;
    run_until(FRAME + 2 * HT);

    chk("addr_max", maxaddr,
        ((VV - 1) / 4) * FB_W + (HV - 1) / 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 SHALL have port clk, input, 1, the single pixel clock (25 MHz).
REQ-006 SHALL have port reset, input, 1, synchronous, active-low reset sampled on the rising edge of clk.
REQ-007 SHALL have port fb_addr, output, 15, framebuffer read address.
REQ-008 SHALL have port fb_data, input, 3, framebuffer colour {R,G,B}, valid exactly one clk after fb_addr.
REQ-009 SHALL have ports VGA_R, VGA_G and VGA_B, output, 4 each, colour channels to the DAC.
REQ-010 SHALL have ports VGA_HS and VGA_VS, output, 1 each, active-low syncs.
REQ-011 SHALL have port VGA_BLANK, output, 1, high while the pixel is visible (active-low blank).
REQ-012 SHALL have port VGA_SYNC, output, 1, held at 0.
REQ-013 SHALL have port vblank, output, 1, high while v_cnt >= V_VISIBLE, so the CPU can plot tear-free.

Function
REQ-014 SHALL keep h_cnt in 0..H_TOTAL-1 (H_TOTAL = 800) and advance it every clk, wrapping 799 -> 0.
REQ-015 SHALL keep v_cnt in 0..V_TOTAL-1 (V_TOTAL = 525), advance it only on an h_cnt wrap, and wrap 524 -> 0.
REQ-016 SHALL treat a pixel as visible when h_cnt < 640 and v_cnt < 480.
REQ-017 SHALL treat a count as in hsync when 656 <= h_cnt < 752, and in vsync when 490 <= v_cnt < 492.
REQ-018 SHALL map the 160x120 framebuffer at 4x4 screen pixels per cell: fb_addr = (v_cnt>>2)*160 + (h_cnt>>2), computed as (y<<7)+(y<<5)+x with no multiplier, with a maximum of 19199.
REQ-019 SHALL drive fb_addr to 0 outside the visible region.
REQ-020 SHALL register fb_addr, giving stage 1 = count + 1 clk.
REQ-021 SHALL capture fb_data at stage 2.
REQ-022 SHALL register the VGA outputs at stage 3, for a total latency of 3 clk from a counter value to the pins.
REQ-023 SHALL delay hsync, vsync, visible and vblank through an identical 3-stage pipeline so that they stay aligned with colour.
REQ-024 SHALL expand colour bit b to 4'b1111 when b=1 and to 4'b0000 when b=0, with bit 2 -> R, bit 1 -> G, bit 0 -> B.
REQ-025 SHALL force VGA_R/G/B to 0 whenever the delayed visible flag is low, whatever the value of fb_data.
REQ-026 SHALL restart counting from h_cnt=0, v_cnt=0 on the edge where reset rises, and SHALL begin the first visible pixel on the pins 3 clk later.

Reset
REQ-027 SHALL, while reset=0, hold h_cnt=0, v_cnt=0 and clear all pipeline stages.
REQ-028 SHALL, while reset=0, drive fb_addr=0, VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK=0 and vblank=0.
REQ-029 SHALL make reset asserted mid-line or mid-frame take effect on the next edge with no partial line completed, and SHALL clear pipeline contents rather than drain them.

Structure
REQ-030 SHALL place the timing constants (H_*, V_*, H_TOTAL, V_TOTAL, FB_W=160, FB_H=120, FB_AW=15) in shared package vga_pkg, which the plot-side adapter also uses.
REQ-031 SHALL contain one sub-module, vga_timing, holding the counters and producing h_cnt, v_cnt, visible, hsync_n and vsync_n; vga_scanout SHALL add the address computation, the pipeline and colour expansion.
REQ-032 SHALL be stateful only through the counters and the 3-stage pipeline, with no FSM beyond the counters.

Verification
REQ-033 SHALL have a bench check that, after reset release, VGA_HS falls 656+3 clk later, stays low for 96 clk, and repeats with a period of 800 clk.
REQ-034 SHALL have a bench check that VGA_VS is low for exactly 2 lines (1600 clk) starting at line 490, with a frame period of 420000 clk.
REQ-035 SHALL have a bench where a model RAM with 1-clk latency holds cell (x=5,y=2)=3'b101 and the rest 0; fb_addr SHALL equal 325 for h_cnt 20..23 on lines 8..11, and VGA_R=VGA_B=4'hF, VGA_G=0 SHALL appear exactly on screen pixels x 20..23, y 8..11.
REQ-036 SHALL have a bench that drives fb_data=3'b111 constantly; the colour pins SHALL be 0 for all h_cnt >= 640 (delayed) and on lines >= 480, and VGA_BLANK SHALL be 0 there.
REQ-037 SHALL have a bench that asserts reset=0 at h_cnt=300, v_cnt=200 for 1 clk; the next edge SHALL show the reset values on every output, and after release the timing SHALL restart from line 0, column 0.
REQ-038 SHALL have a bench check that fb_addr reaches 19199 at h_cnt=636..639, v_cnt=476..479, never exceeds 19199, and wraps to 0 at the next visible pixel.
